// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals for the write arbiter.
// Use the slave modport on the arbiter and the master modport on whatever drives it.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
    logic                          wr_inhibit_i;
    logic [ADDR_WIDTH:0]           rd_ptr_gray_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic                          wr_en_o;
    logic [ADDR_WIDTH-1:0]         wr_addr_o;
    logic [DATA_WIDTH-1:0]         wr_data_o;
    logic [ADDR_WIDTH:0]           wr_ptr_gray_o;
    logic                          full_o;

    modport master (
        output req_i, data_i, wr_inhibit_i, rd_ptr_gray_i,
        input  gnt_o, wr_en_o, wr_addr_o, wr_data_o, wr_ptr_gray_o, full_o
    );

    modport slave (
        input  req_i, data_i, wr_inhibit_i, rd_ptr_gray_i,
        output gnt_o, wr_en_o, wr_addr_o, wr_data_o, wr_ptr_gray_o, full_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write side of the async FIFO: round-robin arbitration of NUM_REQ writers onto
// one RAM write port, write-pointer ownership (binary + Gray) and full detection.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = ADDR_WIDTH;

    logic [AW:0]           wbin_q, wbin_d;
    logic [IW-1:0]         last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [AW:0]           wr_ptr_gray_q, wr_ptr_gray_d;
    logic                  full_q, full_d;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic [IW-1:0]         cand;
    logic                  found;
    logic                  accept;
    logic [AW:0]           gray_nxt;
    logic [AW:0]           rd_full_pat;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            words[k] = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign accept = (|bus.req_i) & ~full_q & ~bus.wr_inhibit_i & rstn_i;

    // Search starts just past the last winner and wraps, so every holder gets a turn.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_q;
        cand    = '0;
        found   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IW'((int'(last_q) + off) % NUM_REQ);
            if (accept && !found && bus.req_i[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        wbin_d        = wbin_q + {{AW{1'b0}}, accept};
        last_d        = accept ? gnt_idx : last_q;
        wr_en_d       = accept;
        wr_addr_d     = accept ? wbin_q[AW-1:0] : wr_addr_q;
        wr_data_d     = accept ? words[gnt_idx] : wr_data_q;
        wr_ptr_gray_d = wbin_q ^ (wbin_q >> 1);
        // Full when the next write pointer sits exactly one lap ahead of the read pointer.
        gray_nxt      = wbin_d ^ (wbin_d >> 1);
        rd_full_pat   = {~bus.rd_ptr_gray_i[AW:AW-1], bus.rd_ptr_gray_i[AW-2:0]};
        full_d        = (gray_nxt == rd_full_pat);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wbin_q        <= '0;
            last_q        <= IW'(NUM_REQ - 1);
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_ptr_gray_q <= '0;
            full_q        <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            last_q        <= last_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            full_q        <= full_d;
        end
    end

    assign bus.gnt_o         = gnt;
    assign bus.wr_en_o       = wr_en_q;
    assign bus.wr_addr_o     = wr_addr_q;
    assign bus.wr_data_o     = wr_data_q;
    assign bus.wr_ptr_gray_o = wr_ptr_gray_q;
    assign bus.full_o        = full_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table-driven grant vectors, a write scoreboard,
// and hand sequences for fill/release, wrap-around and mid-stream reset.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 5;

    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct {
        logic          rstn;
        logic          inh;
        logic [NR-1:0] req;
        logic [NR-1:0] gnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t          vecs[$];
    wr_t           sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW:0]   m_wbin  = '0;
    logic [AW:0]   rd_bin  = '0;
    logic [DW-1:0] words [NR];

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check gnt before the rising edge,
    // check registered outputs just after it.
    task automatic cycle(input logic rstn, input logic inh,
                         input logic [NR-1:0] req, input logic [NR-1:0] exp_gnt);
        logic          exp_we;
        logic [AW:0]   exp_gray;
        logic [AW:0]   nxt;
        logic [AW:0]   diff;
        logic          exp_full;
        wr_t           w;
        rstn_i            = rstn;
        bus.wr_inhibit_i  = inh;
        bus.req_i         = req;
        bus.rd_ptr_gray_i = gray(rd_bin);
        for (int k = 0; k < NR; k++) bus.data_i[k*DW +: DW] = words[k];
        #1;
        check("gnt", 32'(bus.gnt_o), 32'(exp_gnt));
        exp_we   = rstn && (exp_gnt != '0);
        exp_gray = rstn ? gray(m_wbin) : '0;
        if (exp_we) begin
            for (int k = 0; k < NR; k++) begin
                if (exp_gnt[k]) begin
                    w.addr = m_wbin[AW-1:0];
                    w.data = words[k];
                    sb.push_back(w);
                    words[k] = DW'($urandom);
                end
            end
        end
        nxt      = !rstn ? '0 : m_wbin + {{AW{1'b0}}, exp_we};
        diff     = nxt - rd_bin;
        exp_full = rstn && (diff == (AW+1)'(1 << AW));
        @(posedge clk_i);
        #1;
        m_wbin = nxt;
        if (!rstn) sb.delete();
        check("wr_en", 32'(bus.wr_en_o), 32'(exp_we));
        if (bus.wr_en_o) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got unexpected write addr %0h expected none", bus.wr_addr_o);
            end else begin
                w = sb.pop_front();
                check("wr_addr", 32'(bus.wr_addr_o), 32'(w.addr));
                check("wr_data", 32'(bus.wr_data_o), 32'(w.data));
            end
        end else if (exp_we && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        check("wr_ptr_gray", 32'(bus.wr_ptr_gray_o), 32'(exp_gray));
        check("full", 32'(bus.full_o), 32'(exp_full));
        @(negedge clk_i);
    endtask

    initial begin
        rstn_i            = 1'b0;
        bus.req_i         = '0;
        bus.data_i        = '0;
        bus.wr_inhibit_i  = 1'b0;
        bus.rd_ptr_gray_i = '0;
        for (int k = 0; k < NR; k++) words[k] = DW'($urandom);

        //      rstn  inh   req       expected gnt
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0010});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0100});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1000});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0010});
        vecs.push_back('{1'b1, 1'b0, 4'b1001, 4'b1000});
        vecs.push_back('{1'b1, 1'b0, 4'b1001, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100});
        vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000});
        vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b1000});
        vecs.push_back('{1'b1, 1'b0, 4'b1111, 4'b0001});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000});

        @(negedge clk_i);
        cycle(1'b0, 1'b0, 4'b1111, 4'b0000);
        check("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data_o), 32'd0);

        foreach (vecs[i]) cycle(vecs[i].rstn, vecs[i].inh, vecs[i].req, vecs[i].gnt);

        // Fill to 32 words with the read side stalled, then free one slot.
        rd_bin = '0;
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 4'b0010, 4'b0010);
        check("fill_full", 32'(bus.full_o), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b0010, 4'b0000);
        check("fill_gray", 32'(bus.wr_ptr_gray_o), 32'h30);
        rd_bin = (AW+1)'(1);
        cycle(1'b1, 1'b0, 4'b0010, 4'b0000);
        check("release_full", 32'(bus.full_o), 32'd0);
        cycle(1'b1, 1'b0, 4'b0010, 4'b0010);
        cycle(1'b1, 1'b0, 4'b0010, 4'b0000);
        check("refill_full", 32'(bus.full_o), 32'd1);

        // Wrap the pointer past 63 with the reader keeping up.
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 70; i++) begin
            rd_bin = m_wbin;
            cycle(1'b1, 1'b0, 4'b0001, 4'b0001);
        end
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("wrap_gray", 32'(bus.wr_ptr_gray_o), 32'h05);
        cycle(1'b1, 1'b0, 4'b0001, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0001, 4'b0000);
        check("midrst_wr_en", 32'(bus.wr_en_o), 32'd0);
        check("midrst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        check("midrst_wr_data", 32'(bus.wr_data_o), 32'd0);
        check("midrst_gray", 32'(bus.wr_ptr_gray_o), 32'd0);
        check("midrst_full", 32'(bus.full_o), 32'd0);
        rd_bin = '0;
        cycle(1'b1, 1'b0, 4'b1010, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
